// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: the writeback stage normally wins, and long-latency
// results wait in a small FIFO. A buffered head that is passed over too long is force-granted.
module regfile_write_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_wdata,
    output logic            wb_stall,
    input  logic            lu_valid,
    output logic            lu_ready,
    input  logic [4:0]      lu_rd_addr,
    input  logic [XLEN-1:0] lu_wdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     lu_pending_mask
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO_CNT = {(AW+1){1'b0}};
    localparam logic [3:0]  LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t          state_r, state_next_s;
    logic [3:0]      starve_r, starve_next_s;
    logic [AW:0]     count_r, occ_if_deq_s;
    logic [AW-1:0]   wptr_r, rptr_r;
    logic [DEPTH-1:0] valid_r;
    logic [4:0]      addr_mem_r [DEPTH];
    logic [XLEN-1:0] data_mem_r [DEPTH];
    logic [31:0]     mask_r, mask_next_s;
    logic            wb_req_s, head_avail_s, enq_s;
    logic            grant_wb_raw_s, grant_head_raw_s, stall_raw_s;
    logic            grant_wb_s, grant_head_s;

    assign wb_req_s     = wb_valid && (wb_rd_addr != 5'd0);
    assign head_avail_s = (count_r != ZERO_CNT);
    assign lu_ready     = rst && (count_r != FULL_CNT);
    // Writes to x0 complete the handshake but never occupy a slot.
    assign enq_s        = lu_valid && lu_ready && (lu_rd_addr != 5'd0);
    assign occ_if_deq_s = count_r + {{AW{1'b0}}, enq_s} - {{AW{1'b0}}, head_avail_s};

    // Grants are suppressed while reset is held so nothing reaches the register file.
    assign grant_wb_s      = rst && grant_wb_raw_s;
    assign grant_head_s    = rst && grant_head_raw_s;
    assign wb_stall        = rst && stall_raw_s;
    assign lu_pending_mask = mask_r;

    // Arbitration and next-state decode.
    always_comb begin
        grant_wb_raw_s   = 1'b0;
        grant_head_raw_s = 1'b0;
        stall_raw_s      = 1'b0;
        state_next_s     = state_r;
        starve_next_s    = starve_r;
        case (state_r)
            IDLE: begin
                grant_wb_raw_s = wb_req_s;
                state_next_s   = enq_s ? WAIT : IDLE;
            end
            WAIT: begin
                if (wb_req_s) begin
                    grant_wb_raw_s = 1'b1;
                    starve_next_s  = (starve_r == 4'hF) ? starve_r : starve_r + 4'd1;
                    state_next_s   = (starve_r >= LIMIT_M1) ? FORCE : WAIT;
                end else begin
                    grant_head_raw_s = head_avail_s;
                    starve_next_s    = 4'd0;
                    state_next_s     = (occ_if_deq_s == ZERO_CNT) ? IDLE : WAIT;
                end
            end
            FORCE: begin
                grant_head_raw_s = head_avail_s;
                stall_raw_s      = wb_req_s;
                starve_next_s    = 4'd0;
                state_next_s     = (occ_if_deq_s == ZERO_CNT) ? IDLE : WAIT;
            end
            default: begin
                state_next_s  = IDLE;
                starve_next_s = 4'd0;
            end
        endcase
    end

    // Register-file port mux driven by whichever source holds the grant.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = {XLEN{1'b0}};
        if (grant_head_s) begin
            rf_we    = 1'b1;
            rf_waddr = addr_mem_r[rptr_r];
            rf_wdata = data_mem_r[rptr_r];
        end else if (grant_wb_s) begin
            rf_we    = 1'b1;
            rf_waddr = wb_rd_addr;
            rf_wdata = wb_wdata;
        end else begin
            rf_we    = 1'b0;
        end
    end

    // Pending mask reflects buffer contents after this cycle's enqueue/dequeue.
    always_comb begin
        mask_next_s = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            mask_next_s = mask_next_s
                | ((enq_s && (wptr_r == AW'(i))) ? (32'd1 << lu_rd_addr) : 32'd0)
                | ((valid_r[i] && !(grant_head_s && (rptr_r == AW'(i))))
                   ? (32'd1 << addr_mem_r[i]) : 32'd0);
        end
    end

    // FIFO storage, pointers, FSM and mask registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= IDLE;
            starve_r <= 4'd0;
            count_r  <= ZERO_CNT;
            wptr_r   <= {AW{1'b0}};
            rptr_r   <= {AW{1'b0}};
            valid_r  <= {DEPTH{1'b0}};
            mask_r   <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= 5'd0;
                data_mem_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            state_r  <= state_next_s;
            starve_r <= starve_next_s;
            mask_r   <= mask_next_s;
            count_r  <= count_r + {{AW{1'b0}}, enq_s} - {{AW{1'b0}}, grant_head_s};
            if (enq_s) begin
                addr_mem_r[wptr_r] <= lu_rd_addr;
                data_mem_r[wptr_r] <= lu_wdata;
                valid_r[wptr_r]    <= 1'b1;
                wptr_r             <= wptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (grant_head_s) begin
                valid_r[rptr_r] <= 1'b0;
                rptr_r          <= rptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
